// File: rtl/pipeline_credit_pkg.sv
// Shared defaults and types for the credit-managed pipeline output FIFO.
package pipeline_credit_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LATENCY    = 2;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_CREDIT_W   = $clog2(DEF_DEPTH + 1);

    typedef logic [DEF_CREDIT_W-1:0] credit_t;

endpackage

// File: rtl/pipeline_credit_fifo_mem.sv
// Result store: register array with wrapping head/tail pointers and occupancy.
module pipeline_credit_fifo_mem
    import pipeline_credit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] occ_q, occ_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = wrap_inc(tail_q);
        end
        if (pop) begin
            head_d = wrap_inc(head_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload needs no reset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = (occ_q != '0);
    assign out_data  = out_valid ? mem_q[head_q] : '0;
    assign occupancy = occ_q;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && (occ_q == CW'(DEPTH)))
    );

endmodule

// File: rtl/pipeline_credit_fifo.sv
// Credit gate and valid tracker for a fixed-latency stall-free pipeline,
// capturing its results into an output FIFO that can never overflow.
module pipeline_credit_fifo
    import pipeline_credit_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         issue,
    input  logic [DATA_WIDTH-1:0]        pipe_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   credits
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [CW-1:0]      occupancy;
    logic [CW-1:0]      inflight;
    logic               push;
    logic               pop;

    // rst_n gate keeps in_ready low while reset is held.
    assign in_ready = rst_n && (credits_q != '0);
    assign issue    = in_valid && in_ready;
    assign push     = valid_q[LATENCY-1];
    assign pop      = out_valid && out_ready;
    assign credits  = credits_q;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = issue;
        credits_d  = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !issue) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            credits_q <= CW'(DEPTH);
        end else begin
            valid_q   <= valid_d;
            credits_q <= credits_d;
        end
    end

    pipeline_credit_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (pipe_data),
        .pop        (pop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .occupancy  (occupancy)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(valid_q[i]);
        end
    end

    a_credit_balance: assert property (
        @(posedge clk) disable iff (!rst_n)
        (32'(credits_q) + 32'(inflight) + 32'(occupancy)) == 32'(DEPTH)
    );

endmodule

// File: tb/tb_pipeline_credit_fifo.sv
// Directed bench with a reference model of credits/occupancy and a result queue.
module tb_pipeline_credit_fifo;
    import pipeline_credit_pkg::*;

    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          issue;
    logic [DW-1:0] pipe_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    credit_t       credits;

    always #5 clk = ~clk;

    pipeline_credit_fifo #(
        .DATA_WIDTH (DW),
        .LATENCY    (LAT),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .issue      (issue),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .credits    (credits)
    );

    int            n_pass = 0;
    int            n_fail = 0;
    int            n_total = 0;
    logic [DW-1:0] exp_q[$];
    logic          hist_v[LAT];
    logic [DW-1:0] hist_d[LAT];
    credit_t       m_cred;
    int            m_occ;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
        m_cred = credit_t'(DEPTH);
        m_occ  = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input logic iv, input logic ordy, input logic [DW-1:0] d);
        logic exp_issue;
        logic exp_push;
        logic exp_pop;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        pipe_data = hist_v[LAT-1] ? hist_d[LAT-1] : $urandom();
        #1;
        exp_issue = iv && (m_cred != 0);
        exp_push  = hist_v[LAT-1];
        exp_pop   = (m_occ != 0) && ordy;
        chk("credits", 32'(credits), 32'(m_cred));
        chk("in_ready", 32'(in_ready), 32'(m_cred != 0));
        chk("issue", 32'(issue), 32'(exp_issue));
        chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
        if (m_occ != 0) begin
            chk("out_data", out_data, exp_q[0]);
        end
        if (exp_issue) begin
            exp_q.push_back(d);
        end
        if (exp_pop) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        m_occ  = m_occ + int'(exp_push) - int'(exp_pop);
        m_cred = m_cred - credit_t'(exp_issue) + credit_t'(exp_pop);
        for (int i = LAT - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_d[i] = hist_d[i-1];
        end
        hist_v[0] = exp_issue;
        hist_d[0] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        pipe_data = '0;
        model_reset();

        @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_credits", 32'(credits), 32'(DEPTH));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // single transaction
        cyc(1'b1, 1'b1, 32'h6A);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h0);

        // fill with downstream stalled, then drain
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'(200 + i));
        chk("full_credits", 32'(credits), 32'd0);
        chk("full_out_data_stable", out_data, 32'd200);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 32'h0);

        // back-to-back streaming
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 32'(i));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);

        // alternating back-pressure across pointer wrap
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'(i % 2), 32'(300 + i));
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 32'h0);

        // reset with two stored and two in flight
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'(400 + i));
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_credits", 32'(credits), 32'(DEPTH));
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_issue", 32'(issue), 32'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'(i % 2), 32'h0);

        // recovery after reset
        cyc(1'b1, 1'b1, 32'h77);
        cyc(1'b1, 1'b1, 32'h78);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h0);

        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
